// File: rtl/sys_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// sys_cmd_ctrl_if
// Bus bundle around the command controller. It carries the UART RX/TX byte
// handshakes, the register-file port and the ALU port.
//   master : the controller's view. It receives RX bytes and read/ALU
//            results, and it drives TX bytes and the register/ALU strobes.
//   slave  : the environment's view (UART, register file, ALU).
// Signal widths follow DATA_WIDTH / ADDR_WIDTH / ALU_OUT_WIDTH / FUN_WIDTH.
// ---------------------------------------------------------------------------
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 2*DATA_WIDTH,
  parameter int FUN_WIDTH     = 4
);
  logic [DATA_WIDTH-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic                     TX_BUSY;
  logic [DATA_WIDTH-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     WR_EN;
  logic                     RD_EN;
  logic [ADDR_WIDTH-1:0]    ADDRESS;
  logic [DATA_WIDTH-1:0]    WR_DATA;
  logic [DATA_WIDTH-1:0]    RD_DATA;
  logic                     RD_DATA_VLD;
  logic                     ALU_EN;
  logic [FUN_WIDTH-1:0]     ALU_FUN;
  logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
  logic                     ALU_OUT_VLD;
  logic                     CLK_GATE_EN;
  logic                     CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, TX_BUSY, RD_DATA, RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD,
    output TX_P_DATA, TX_D_VLD, WR_EN, RD_EN, ADDRESS, WR_DATA, ALU_EN, ALU_FUN,
           CLK_GATE_EN, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, TX_BUSY, RD_DATA, RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD,
    input  TX_P_DATA, TX_D_VLD, WR_EN, RD_EN, ADDRESS, WR_DATA, ALU_EN, ALU_FUN,
           CLK_GATE_EN, CMD_ERR
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// sys_cmd_ctrl
// UART command decoder. It parses byte frames and turns them into
// register-file writes and reads or ALU operations. Read data and ALU
// results are sent back over the UART TX byte handshake.
//   AA addr data   : register write (no response)
//   BB addr        : register read, one response byte
//   CC A B fun     : store A->reg0 and B->reg1, run ALU, return result LSB first
//   DD fun         : run ALU on current operands, return result LSB first
// Ports:
//   CLK, RST : clock and synchronous active-high reset
//   bus      : sys_cmd_ctrl_if.master (RX, TX, register and ALU signals)
// Optional build macro CMD_TIMEOUT_EN: a frame that stalls in a GET_* state
// for TIMEOUT_CYCLES cycles is aborted with a CMD_ERR pulse. When the macro
// is not defined, GET_* states wait indefinitely and no counter exists.
// All outputs are registered, so every output is 0 after a reset edge.
// ---------------------------------------------------------------------------
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 2*DATA_WIDTH,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           CLK,
  input  logic           RST,
  sys_cmd_ctrl_if.master bus
);

  localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CW     = $clog2(NBYTES + 1);

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_NOP = DATA_WIDTH'(8'hDD);

  if ((ALU_OUT_WIDTH % DATA_WIDTH) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sys_cmd_ctrl: ALU_OUT_WIDTH must be a multiple of DATA_WIDTH and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN,
    RD_WAIT, ALU_WAIT, TX_LOAD, TX_WAIT
  } state_e;

  state_e state_q, state_d;

  logic                     rx_vld;
  logic [DATA_WIDTH-1:0]    rx_byte;
  logic                     in_get;
  logic                     timeout;

  logic                     is_rd_q, is_rd_d;          // GET_ADDR belongs to a read frame
  logic                     alu_start_q, alu_start_d;  // ALU_EN still owed, one cycle after gate-on
  logic [ALU_OUT_WIDTH-1:0] tx_buf_q, tx_buf_d;        // response bytes, shifted out LSB first
  logic [CW-1:0]            tx_left_q, tx_left_d;      // bytes still to send, including the current one

  logic                     tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;
  logic                     clk_gate_q, clk_gate_d;
  logic                     cmd_err_q, cmd_err_d;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;

  assign in_get = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_OPA) ||
                  (state_q == GET_OPB)  || (state_q == GET_FUN);

`ifdef CMD_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  // Counts idle cycles spent inside a frame. Any byte or leaving GET_* restarts it.
  always_comb begin
    to_cnt_d = to_cnt_q + TOW'(1);
    if (!in_get || rx_vld) to_cnt_d = '0;
  end

  assign timeout = in_get && !rx_vld && (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- next state ----------------
  // RX bytes are ignored outside IDLE/GET_*. In the wait states only the
  // handshake inputs are looked at, so a byte that coincides with them is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rx_vld) begin
        if (rx_byte == OP_WR || rx_byte == OP_RD) state_d = GET_ADDR;
        else if (rx_byte == OP_ALU)               state_d = GET_OPA;
        else if (rx_byte == OP_NOP)               state_d = GET_FUN;
      end
      GET_ADDR: if (rx_vld) state_d = is_rd_q ? RD_WAIT : GET_DATA;
      GET_DATA: if (rx_vld) state_d = IDLE;
      GET_OPA:  if (rx_vld) state_d = GET_OPB;
      GET_OPB:  if (rx_vld) state_d = GET_FUN;
      GET_FUN:  if (rx_vld) state_d = ALU_WAIT;
      RD_WAIT:  if (bus.RD_DATA_VLD) state_d = TX_LOAD;
      ALU_WAIT: if (!alu_start_q && bus.ALU_OUT_VLD) state_d = TX_LOAD;
      TX_LOAD:  if (!bus.TX_BUSY) state_d = TX_WAIT;
      TX_WAIT:  if (bus.TX_BUSY) state_d = (tx_left_q == CW'(1)) ? IDLE : TX_LOAD;
      default:  state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // ---------------- outputs / datapath ----------------
  always_comb begin
    is_rd_d     = is_rd_q;
    alu_start_d = alu_start_q;
    tx_buf_d    = tx_buf_q;
    tx_left_d   = tx_left_q;
    tx_vld_d    = tx_vld_q;
    tx_data_d   = tx_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    alu_en_d    = 1'b0;
    alu_fun_d   = alu_fun_q;
    clk_gate_d  = clk_gate_q;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (rx_vld) begin
        is_rd_d = (rx_byte == OP_RD);
        if (rx_byte != OP_WR && rx_byte != OP_RD && rx_byte != OP_ALU && rx_byte != OP_NOP)
          cmd_err_d = 1'b1;
      end
      GET_ADDR: if (rx_vld) begin
        addr_d  = ADDR_WIDTH'(rx_byte);
        rd_en_d = is_rd_q;
      end
      GET_DATA: if (rx_vld) begin
        wr_data_d = rx_byte;
        wr_en_d   = 1'b1;
      end
      // Operands are placed in the fixed ALU operand registers 0 and 1.
      GET_OPA: if (rx_vld) begin
        addr_d    = '0;
        wr_data_d = rx_byte;
        wr_en_d   = 1'b1;
      end
      GET_OPB: if (rx_vld) begin
        addr_d    = ADDR_WIDTH'(1);
        wr_data_d = rx_byte;
        wr_en_d   = 1'b1;
      end
      // The clock gate is opened first so that the ALU clock is running when ALU_EN arrives.
      GET_FUN: if (rx_vld) begin
        alu_fun_d   = FUN_WIDTH'(rx_byte);
        clk_gate_d  = 1'b1;
        alu_start_d = 1'b1;
      end
      RD_WAIT: if (bus.RD_DATA_VLD) begin
        tx_buf_d  = ALU_OUT_WIDTH'(bus.RD_DATA);
        tx_left_d = CW'(1);
      end
      ALU_WAIT: begin
        if (alu_start_q) begin
          alu_en_d    = 1'b1;
          alu_start_d = 1'b0;
        end else if (bus.ALU_OUT_VLD) begin
          clk_gate_d = 1'b0;
          tx_buf_d   = bus.ALU_OUT;
          tx_left_d  = CW'(NBYTES);
        end
      end
      TX_LOAD: if (!bus.TX_BUSY) begin
        tx_vld_d  = 1'b1;
        tx_data_d = tx_buf_q[DATA_WIDTH-1:0];
      end
      // The byte stays presented until the UART signals busy (it has taken the byte).
      TX_WAIT: if (bus.TX_BUSY) begin
        tx_vld_d  = 1'b0;
        tx_buf_d  = tx_buf_q >> DATA_WIDTH;
        tx_left_d = tx_left_q - CW'(1);
      end
      default: ;
    endcase
    if (timeout) cmd_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      is_rd_q     <= 1'b0;
      alu_start_q <= 1'b0;
      tx_buf_q    <= '0;
      tx_left_q   <= '0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      clk_gate_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      is_rd_q     <= is_rd_d;
      alu_start_q <= alu_start_d;
      tx_buf_q    <= tx_buf_d;
      tx_left_q   <= tx_left_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      clk_gate_q  <= clk_gate_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.TX_D_VLD    = tx_vld_q;
  assign bus.TX_P_DATA   = tx_data_q;
  assign bus.WR_EN       = wr_en_q;
  assign bus.RD_EN       = rd_en_q;
  assign bus.ADDRESS     = addr_q;
  assign bus.WR_DATA     = wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.CLK_GATE_EN = clk_gate_q;
  assign bus.CMD_ERR     = cmd_err_q;

endmodule
